// File: rtl/keyed_io_lock.sv
// Key-programmable I/O lock around an external keyed combinational core:
// serial key load with length check, failed-attempt lockout, two-stage masked data path.
module keyed_io_lock #(
    parameter int IN_W     = 36,
    parameter int OUT_W    = 7,
    parameter int LUT_N    = 1,
    parameter int MAX_FAIL = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_valid,
    input  logic                 key_bit,
    input  logic                 key_last,
    output logic                 key_ready,
    output logic                 key_err,
    output logic                 key_ok,
    output logic [1:0]           lock_state,
    output logic                 unlocked,
    output logic [3:0]           fail_cnt,
    input  logic                 in_valid,
    input  logic [IN_W-1:0]      in_data,
    output logic [IN_W-1:0]      core_in,
    output logic                 core_in_valid,
    input  logic [OUT_W-1:0]     core_out,
    output logic [4*LUT_N-1:0]   lut_key,
    output logic                 out_valid,
    output logic [OUT_W-1:0]     out_data
);

    localparam int K  = IN_W + OUT_W + 4 * LUT_N;
    localparam int CW = $clog2(K + 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DEAD = 2'd3
    } state_t;

    state_t            state_q, state_d;
    // Only the newest K-1 bits are kept; the oldest bit would be shifted out on commit anyway.
    logic [K-2:0]      sh_q, sh_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [K-1:0]      act_q, act_d;
    logic              key_ok_q, key_ok_d;
    logic              key_err_q, key_err_d;
    logic              unlocked_q, unlocked_d;
    logic [3:0]        fail_cnt_q, fail_cnt_d;
    logic [IN_W-1:0]   core_in_q, core_in_d;
    logic              core_in_valid_q, core_in_valid_d;
    logic [OUT_W-1:0]  out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;

    logic [IN_W-1:0]   in_mask;
    logic [OUT_W-1:0]  out_mask;
    logic [K-1:0]      shifted;
    logic              xfer;

    assign in_mask  = act_q[IN_W-1:0];
    assign out_mask = act_q[IN_W+OUT_W-1:IN_W];
    assign shifted  = {key_bit, sh_q};
    assign xfer     = key_valid && (state_q != S_DEAD);

    always_comb begin
        state_d         = state_q;
        sh_d            = sh_q;
        cnt_d           = cnt_q;
        act_d           = act_q;
        key_ok_d        = 1'b0;
        key_err_d       = 1'b0;
        unlocked_d      = unlocked_q;
        fail_cnt_d      = fail_cnt_q;

        if (state_q == S_DEAD) begin
            act_d      = '0;
            unlocked_d = 1'b0;
        end else if (xfer) begin
            sh_d = shifted[K-1:1];
            if (key_last) begin
                cnt_d   = '0;
                state_d = S_IDLE;
                // cnt holds bits before this one, so length == K means cnt == K-1.
                if (cnt_q == CW'(K - 1)) begin
                    act_d      = shifted;
                    key_ok_d   = 1'b1;
                    unlocked_d = 1'b1;
                end else begin
                    key_err_d  = 1'b1;
                    fail_cnt_d = fail_cnt_q + 4'd1;
                    if (fail_cnt_d == 4'(MAX_FAIL)) begin
                        state_d    = S_DEAD;
                        act_d      = '0;
                        unlocked_d = 1'b0;
                    end
                end
            end else begin
                state_d = S_LOAD;
                if (cnt_q != CW'(K + 1))
                    cnt_d = cnt_q + CW'(1);
            end
        end

        core_in_valid_d = in_valid;
        core_in_d       = in_valid ? (in_data ^ in_mask) : core_in_q;
        out_valid_d     = core_in_valid_q;
        out_data_d      = core_in_valid_q ? (core_out ^ out_mask) : out_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            sh_q            <= '0;
            cnt_q           <= '0;
            act_q           <= '0;
            key_ok_q        <= 1'b0;
            key_err_q       <= 1'b0;
            unlocked_q      <= 1'b0;
            fail_cnt_q      <= '0;
            core_in_q       <= '0;
            core_in_valid_q <= 1'b0;
            out_data_q      <= '0;
            out_valid_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            sh_q            <= sh_d;
            cnt_q           <= cnt_d;
            act_q           <= act_d;
            key_ok_q        <= key_ok_d;
            key_err_q       <= key_err_d;
            unlocked_q      <= unlocked_d;
            fail_cnt_q      <= fail_cnt_d;
            core_in_q       <= core_in_d;
            core_in_valid_q <= core_in_valid_d;
            out_data_q      <= out_data_d;
            out_valid_q     <= out_valid_d;
        end
    end

    assign key_ready     = (state_q != S_DEAD);
    assign key_err       = key_err_q;
    assign key_ok        = key_ok_q;
    assign lock_state    = state_q;
    assign unlocked      = unlocked_q;
    assign fail_cnt      = fail_cnt_q;
    assign core_in       = core_in_q;
    assign core_in_valid = core_in_valid_q;
    assign lut_key       = act_q[K-1:IN_W+OUT_W];
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;

endmodule

// File: tb/tb_keyed_io_lock.sv
// Bench for keyed_io_lock: directed key/lockout scenarios plus random traffic,
// every cycle compared against a transaction-level model of the lock.
module tb_keyed_io_lock;

    localparam int IN_W = 4, OUT_W = 3, LUT_N = 1, MAX_FAIL = 2;
    localparam int K = IN_W + OUT_W + 4 * LUT_N;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_valid = 1'b0, key_bit = 1'b0, key_last = 1'b0;
    logic key_ready, key_err, key_ok, unlocked, core_in_valid, out_valid;
    logic [1:0] lock_state;
    logic [3:0] fail_cnt;
    logic in_valid = 1'b0;
    logic [IN_W-1:0] in_data = '0;
    logic [IN_W-1:0] core_in;
    logic [OUT_W-1:0] core_out, out_data;
    logic [4*LUT_N-1:0] lut_key;

    always #5 clk = ~clk;

    keyed_io_lock #(.IN_W(IN_W), .OUT_W(OUT_W), .LUT_N(LUT_N), .MAX_FAIL(MAX_FAIL)) dut (
        .clk(clk), .rst(rst),
        .key_valid(key_valid), .key_bit(key_bit), .key_last(key_last),
        .key_ready(key_ready), .key_err(key_err), .key_ok(key_ok),
        .lock_state(lock_state), .unlocked(unlocked), .fail_cnt(fail_cnt),
        .in_valid(in_valid), .in_data(in_data), .core_in(core_in),
        .core_in_valid(core_in_valid), .core_out(core_out), .lut_key(lut_key),
        .out_valid(out_valid), .out_data(out_data)
    );

    // Stand-in keyed core: a simple function of the masked input and the LUT key.
    function automatic logic [OUT_W-1:0] core_fn(logic [IN_W-1:0] ci, logic [3:0] lk);
        return ci[3:1] ^ lk[2:0];
    endfunction
    assign core_out = core_fn(core_in, lut_key);

    // Reference model state: the current load is just a queue of received bits.
    bit              m_q[$];
    logic [K-1:0]    m_act;
    logic            m_dead, m_unl, m_ok, m_err;
    int              m_fail;
    logic [IN_W-1:0] m_cin;
    logic            m_cinv, m_outv;
    logic [OUT_W-1:0] m_out;

    int  n_cmp = 0, n_bad = 0;
    bit  rand_data = 0;

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_act = '0; m_dead = 0; m_unl = 0; m_ok = 0; m_err = 0; m_fail = 0;
        m_cin = '0; m_cinv = 0; m_outv = 0; m_out = '0;
    endtask

    task automatic model_step();
        logic [IN_W-1:0]  n_cin;
        logic [OUT_W-1:0] n_out;
        if (rst) begin
            model_reset();
            return;
        end
        n_cin = in_valid ? (in_data ^ m_act[IN_W-1:0]) : m_cin;
        n_out = m_cinv ? (core_fn(m_cin, m_act[K-1:IN_W+OUT_W]) ^ m_act[IN_W+OUT_W-1:IN_W]) : m_out;
        m_outv = m_cinv; m_out = n_out;
        m_cinv = in_valid; m_cin = n_cin;
        m_ok = 0; m_err = 0;
        if (!m_dead && key_valid) begin
            m_q.push_back(key_bit);
            if (key_last) begin
                if (m_q.size() == K) begin
                    for (int i = 0; i < K; i++) m_act[i] = m_q[i];
                    m_ok = 1; m_unl = 1;
                end else begin
                    m_err = 1; m_fail++;
                    if (m_fail == MAX_FAIL) begin
                        m_dead = 1; m_act = '0; m_unl = 0;
                    end
                end
                m_q.delete();
            end
        end
    endtask

    // One clock: model advances on the current inputs, then all outputs are compared.
    task automatic step();
        if (rand_data) begin
            in_valid = 1'b1;
            in_data  = 4'($urandom);
        end
        model_step();
        @(posedge clk);
        #1;
        chk("key_ready", 32'(key_ready), 32'(!m_dead));
        chk("lock_state", 32'(lock_state), m_dead ? 32'd3 : (m_q.size() > 0 ? 32'd1 : 32'd0));
        chk("key_ok", 32'(key_ok), 32'(m_ok));
        chk("key_err", 32'(key_err), 32'(m_err));
        chk("unlocked", 32'(unlocked), 32'(m_unl));
        chk("fail_cnt", 32'(fail_cnt), 32'(m_fail));
        chk("lut_key", 32'(lut_key), 32'(m_act[K-1:IN_W+OUT_W]));
        chk("core_in_valid", 32'(core_in_valid), 32'(m_cinv));
        chk("core_in", 32'(core_in), 32'(m_cin));
        chk("out_valid", 32'(out_valid), 32'(m_outv));
        chk("out_data", 32'(out_data), 32'(m_out));
    endtask

    task automatic load(logic [15:0] val, int len);
        for (int i = 0; i < len; i++) begin
            key_valid = 1'b1;
            key_bit   = val[i];
            key_last  = (i == len - 1);
            step();
        end
        key_valid = 1'b0;
        key_last  = 1'b0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int sent, target, dead_cyc;
        model_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
        chk("rst_key_ready", 32'(key_ready), 32'd1);
        chk("rst_lock_state", 32'(lock_state), 32'd0);
        chk("rst_lut_key", 32'(lut_key), 32'd0);

        in_valid = 1'b1; in_data = 4'hA;
        step();
        chk("pin_core_in_plain", 32'(core_in), 32'hA);
        in_valid = 1'b0;
        step();
        chk("pin_out_plain", 32'(out_data), 32'h5);

        load(16'h5A3, K);
        chk("pin_key_ok", 32'(key_ok), 32'd1);
        chk("pin_unlocked", 32'(unlocked), 32'd1);
        chk("pin_lut_B", 32'(lut_key), 32'hB);
        idle(2);
        in_valid = 1'b1; in_data = 4'hA;
        step();
        chk("pin_core_in_masked", 32'(core_in), 32'h9);
        in_valid = 1'b0;
        step();
        chk("pin_out_masked", 32'(out_data), 32'h5);

        load(16'h0123, K - 1);
        chk("pin_err10", 32'(key_err), 32'd1);
        chk("pin_fail1", 32'(fail_cnt), 32'd1);
        chk("pin_lut_kept", 32'(lut_key), 32'hB);
        load(16'h1FFF, K + 2);
        chk("pin_err13", 32'(key_err), 32'd1);
        chk("pin_fail2", 32'(fail_cnt), 32'd2);
        chk("pin_dead", 32'(lock_state), 32'd3);
        chk("pin_dead_ready", 32'(key_ready), 32'd0);
        chk("pin_dead_lut", 32'(lut_key), 32'd0);
        chk("pin_dead_unl", 32'(unlocked), 32'd0);
        load(16'h5A3, K);
        chk("pin_dead_ignore", 32'(key_ok), 32'd0);
        chk("pin_dead_stay", 32'(lock_state), 32'd3);
        rst = 1'b1; step(); rst = 1'b0; step();
        chk("pin_rst_fail", 32'(fail_cnt), 32'd0);
        chk("pin_rst_idle", 32'(lock_state), 32'd0);

        for (int i = 0; i < 6; i++) begin
            key_valid = 1'b1; key_bit = 1'b1; key_last = 1'b0;
            step();
        end
        key_valid = 1'b0;
        rst = 1'b1; step(); rst = 1'b0;
        load(16'h5A3, K);
        chk("pin_midload_ok", 32'(key_ok), 32'd1);
        chk("pin_midload_lut", 32'(lut_key), 32'hB);

        // Continuous traffic across a commit; out_valid must never drop.
        rand_data = 1;
        idle(3);
        load(16'h2C6, K);
        idle(2);
        rand_data = 0;
        in_valid = 1'b1; in_data = 4'hA;
        step();
        chk("pin_stream_core_in", 32'(core_in), 32'hC);
        in_valid = 1'b0;
        step();
        chk("pin_stream_out", 32'(out_data), 32'h7);
        chk("pin_stream_valid", 32'(out_valid), 32'd1);

        sent = 0; target = K; dead_cyc = 0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(149) == 0) || (dead_cyc > 30);
            in_valid  = 1'($urandom);
            in_data   = 4'($urandom);
            key_valid = ($urandom_range(2) != 0);
            key_bit   = 1'($urandom);
            key_last  = key_valid && (sent + 1 >= target);
            if (key_valid) sent++;
            if (key_last || rst) begin
                sent = 0;
                case ($urandom_range(3))
                    0, 1: target = K;
                    2:    target = ($urandom_range(1) != 0) ? K + 1 : K - 1;
                    default: target = $urandom_range(15, 1);
                endcase
            end
            step();
            key_valid = 1'b0; key_last = 1'b0;
            dead_cyc = m_dead ? dead_cyc + 1 : 0;
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
